// File: rtl/player_collision_sampler.sv
// Samples the map tile codes under the player's box across one active frame and, at the
// start of vertical blanking, commits one prioritised code plus a saturating hazard-pixel count.
module player_collision_sampler #(
  parameter int          PLAYER_W    = 32,
  parameter int          PLAYER_H    = 48,
  parameter logic [3:0]  HAZARD_CODE = 4'h5,
  parameter int          CNT_W       = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [10:0]       hcount,
  input  logic [10:0]       vcount,
  input  logic              hblnk,
  input  logic              vblnk,
  input  logic [3:0]        map_code,
  input  logic [11:0]       xpos,
  input  logic [11:0]       ypos,
  output logic [3:0]        current_pix,
  output logic              pix_valid,
  output logic [CNT_W-1:0]  hazard_cnt
);

  typedef enum logic [1:0] {SYNC, SCAN, COMMIT} state_t;

  state_t           state, state_nxt;
  logic             vblnk_d;
  logic             fb;
  logic [11:0]      x_l, y_l;
  logic             hz_seen;
  logic [CNT_W-1:0] hz_acc;
  logic [3:0]       max_acc;
  logic             clr_acc, latch_pos, do_commit, acc_en;
  logic             in_box;
  logic [12:0]      h13, v13, xl13, yl13, xr13, yb13;

  // vblnk_d resets high so a reset taken during blanking cannot fake a frame boundary
  always_ff @(posedge clk) begin
    if (rst) vblnk_d <= 1'b1;
    else     vblnk_d <= vblnk;
  end

  assign fb = vblnk & ~vblnk_d;

  always_ff @(posedge clk) begin
    if (rst) state <= SYNC;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      SYNC:    if (fb) state_nxt = SCAN;
      SCAN:    if (fb) state_nxt = COMMIT;
      COMMIT:  state_nxt = SCAN;
      default: state_nxt = SYNC;
    endcase
  end

  always_comb begin
    clr_acc   = 1'b0;
    latch_pos = 1'b0;
    do_commit = 1'b0;
    acc_en    = 1'b0;
    case (state)
      SYNC: begin
        clr_acc   = fb;
        latch_pos = fb;
      end
      SCAN: begin
        acc_en    = 1'b1;
        latch_pos = fb;
      end
      COMMIT: begin
        do_commit = 1'b1;
        clr_acc   = 1'b1;
        latch_pos = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x_l <= '0;
      y_l <= '0;
    end else if (latch_pos) begin
      x_l <= xpos;
      y_l <= ypos;
    end
  end

  // 13-bit compare so a box near the 12-bit limit cannot wrap its right/bottom edge
  assign h13  = {2'b00, hcount};
  assign v13  = {2'b00, vcount};
  assign xl13 = {1'b0, x_l};
  assign yl13 = {1'b0, y_l};
  assign xr13 = xl13 + 13'(PLAYER_W);
  assign yb13 = yl13 + 13'(PLAYER_H);
  assign in_box = (h13 >= xl13) && (h13 < xr13) && (v13 >= yl13) && (v13 < yb13)
                  && !hblnk && !vblnk;

  always_ff @(posedge clk) begin
    if (rst || clr_acc) begin
      hz_seen <= 1'b0;
      hz_acc  <= '0;
      max_acc <= '0;
    end else if (acc_en && in_box) begin
      if (map_code == HAZARD_CODE) begin
        hz_seen <= 1'b1;
        if (hz_acc != {CNT_W{1'b1}}) hz_acc <= hz_acc + CNT_W'(1);
      end else if (map_code > max_acc) begin
        max_acc <= map_code;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      current_pix <= '0;
      hazard_cnt  <= '0;
      pix_valid   <= 1'b0;
    end else begin
      pix_valid <= do_commit;
      if (do_commit) begin
        current_pix <= hz_seen ? HAZARD_CODE : max_acc;
        hazard_cnt  <= hz_acc;
      end
    end
  end

endmodule

// File: doc/player_collision_sampler.md
Name: player_collision_sampler

Overview:
- Sits directly upstream of the HP controller. Produces the 4-bit tile code the player is standing on.
- Snoops the VGA timing stream (hcount/vcount/blanking) and the map pixel code.
- Collects the codes inside the player's bounding box over one active frame.
- At the start of vertical blanking, commits one prioritised code, held stable for the whole next frame.

Parameters:
- PLAYER_W, 32, player bounding-box width in pixels
- PLAYER_H, 48, player bounding-box height in pixels
- HAZARD_CODE, 4'h5, tile code with absolute priority (damage tile)
- CNT_W, 12, width of the saturating hazard pixel counter

Ports:
- clk  in  1  system clock (pixel clock domain)
- rst  in  1  synchronous, active-high reset
- hcount  in  11  horizontal pixel position
- vcount  in  11  vertical pixel position
- hblnk  in  1  horizontal blanking
- vblnk  in  1  vertical blanking
- map_code  in  4  map tile code at (hcount,vcount); same-cycle aligned with counters
- xpos  in  12  player box left edge
- ypos  in  12  player box top edge
- current_pix  out  4  committed code for the last full frame
- pix_valid  out  1  one-cycle strobe when current_pix is updated
- hazard_cnt  out  CNT_W  committed number of HAZARD_CODE pixels in the box, saturating

Behaviour:
- Reset values: current_pix=0, pix_valid=0, hazard_cnt=0. Internal accumulators and latched position cleared. FSM goes to SYNC.
- Edge detect: vblnk_d is vblnk registered. Frame boundary (fb) is the cycle where vblnk=1 and vblnk_d=0.
- Position latch: at fb, xpos/ypos are copied into x_l/y_l. The box is fixed for the entire following frame, so there is no tearing.
- In-box test, computed in 13-bit arithmetic (no overflow):
  - x_l <= hcount < x_l+PLAYER_W, and
  - y_l <= vcount < y_l+PLAYER_H, and
  - hblnk=0, and vblnk=0.
  - Only the on-screen part of a partially visible box counts. A fully off-screen box yields 0.
- Accumulation, every in-box cycle:
  - hz_seen is set if map_code==HAZARD_CODE.
  - hz_acc increments when map_code==HAZARD_CODE, saturating at 2^CNT_W-1.
  - max_acc becomes max(max_acc, map_code), considering non-hazard codes only.
- Result: HAZARD_CODE if hz_seen, else max_acc. Code 0 means empty/floor.
- FSM states:
  - SYNC: after reset; ignores pixels. At fb: clear accumulators, latch position, go to SCAN. No commit, because the first frame is partial.
  - SCAN: accumulates. At fb, go to COMMIT.
  - COMMIT: one cycle. Register current_pix=result and hazard_cnt=hz_acc, assert pix_valid, clear accumulators, latch position, return to SCAN.
- Latency: fb in cycle N. COMMIT is active in cycle N+1. Outputs and pix_valid are visible in cycle N+2. pix_valid stays high exactly one cycle.
- Outputs hold their values between commits. Nothing changes mid-frame.
- Position latch and accumulator clear in COMMIT take effect before the first active pixel. Vblank is many cycles, so no pixel is lost.
- Simultaneous events: a hazard pixel and a higher non-hazard code in the same frame give HAZARD_CODE.
- xpos/ypos changes mid-frame are ignored until the next fb.
- Reset asserted mid-frame: the partial frame is discarded and the FSM returns to SYNC. The first valid commit follows one complete frame after reset.
- vblnk stuck high: no further fb, so outputs hold.

Test Plan:
- Reset, then stream 2 frames with all map_code=0, box at (100,100) -> pix_valid pulses once per fb starting at the 2nd fb after reset; current_pix=0, hazard_cnt=0.
- 32x48 box region filled with 4'h5 -> current_pix=5, hazard_cnt=1536, pix_valid 2 cycles after fb.
- Box contains codes 2 and 7 plus a single pixel of 5 -> current_pix=5, hazard_cnt=1. Same frame without the 5 pixel -> current_pix=7.
- Box at xpos=630 (640-wide screen), code 3 everywhere -> only 10 columns are counted; current_pix=3. Box at xpos=700 -> current_pix=0.
- Change xpos mid-frame from 100 to 300, hazard only at x=300..331 -> that frame's commit reports 0; the next frame reports 5.
- Assert rst for 1 cycle mid-frame -> outputs are 0 immediately. No pix_valid at the next fb; the first pix_valid comes at the fb after that.
